// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer: FSM state encoding,
// counter-width helper and default timing/order-field sizes.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT
  } state_t;

  localparam int DEF_WORD_PI    = 18;
  localparam int DEF_ORDER_BITS = 10;

  // Bits needed to hold a shift count in 0..order_bits.
  function automatic int cnt_w(input int order_bits);
    return $clog2(order_bits + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_lsb_encoder.sv
// Priority encoder: shift count = (index of least significant set bit) + 1,
// or 0 when the order position field is empty.
module lsb_encoder
  import shift_seq_pkg::*;
#(
  parameter int ORDER_BITS = DEF_ORDER_BITS
) (
  input  logic [ORDER_BITS-1:0]        order_pos,
  output logic [cnt_w(ORDER_BITS)-1:0] n
);

  localparam int CW = cnt_w(ORDER_BITS);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    n = '0;
    for (int i = ORDER_BITS - 1; i >= 0; i--) begin
      if (order_pos[i]) n = CW'(i + 1);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shift-control unit: holds g5 open for n d0-aligned steps and pulses ep2 at
// the end. Long-accumulator mode is built only with SHIFT_SEQ_LONG_EN defined.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WORD_PI     = DEF_WORD_PI,
  parameter int ORDER_BITS  = DEF_ORDER_BITS,
  parameter int LONG_FACTOR = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         d0,
  input  logic                         start,
  input  logic                         dir_left,
  input  logic [ORDER_BITS-1:0]        order_pos,
`ifdef SHIFT_SEQ_LONG_EN
  input  logic                         long_mode,
`endif
  input  logic                         abort,
  output logic                         g5,
  output logic                         shift_left,
  output logic                         ep2,
  output logic                         busy,
  output logic [cnt_w(ORDER_BITS)-1:0] remaining
);

  localparam int CW = cnt_w(ORDER_BITS);

  if (WORD_PI < 1 || LONG_FACTOR < 1) begin : g_bad_param
    $error("shift_sequencer: WORD_PI and LONG_FACTOR must be positive");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] n_enc, n_q, n_d, rem_d;
  logic          dir_q, dir_d;
  logic          g5_d, sl_d, ep2_d, busy_d;
  logic          step;

`ifdef SHIFT_SEQ_LONG_EN
  localparam int MW = (LONG_FACTOR > 1) ? $clog2(LONG_FACTOR) : 1;
  logic          long_q, long_d;
  logic [MW-1:0] mc_q, mc_d;
`endif

  lsb_encoder #(.ORDER_BITS(ORDER_BITS)) u_enc (
    .order_pos (order_pos),
    .n         (n_enc)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dir_d   = dir_q;
    rem_d   = remaining;
    ep2_d   = 1'b0;
`ifdef SHIFT_SEQ_LONG_EN
    long_d  = long_q;
    mc_d    = mc_q;
    step    = !long_q || (mc_q == MW'(LONG_FACTOR - 1));
`else
    step    = 1'b1;
`endif

    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // busy is still high during the ep2 clock, so a start there is dropped.
          if (start && !busy) begin
            state_d = ARM;
            n_d     = n_enc;
            dir_d   = dir_left;
`ifdef SHIFT_SEQ_LONG_EN
            long_d  = long_mode;
`endif
          end
        end
        ARM: begin
          if (d0) begin
            if (n_q == '0) begin
              state_d = IDLE;
              ep2_d   = 1'b1;
            end else begin
              state_d = SHIFT;
              rem_d   = n_q;
`ifdef SHIFT_SEQ_LONG_EN
              mc_d    = '0;
`endif
            end
          end
        end
        SHIFT: begin
          if (d0) begin
            if (step) begin
              rem_d = remaining - CW'(1);
`ifdef SHIFT_SEQ_LONG_EN
              mc_d  = '0;
`endif
              if (remaining == CW'(1)) begin
                state_d = IDLE;
                ep2_d   = 1'b1;
              end
            end
`ifdef SHIFT_SEQ_LONG_EN
            else begin
              mc_d = mc_q + MW'(1);
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    g5_d   = (state_d == SHIFT);
    sl_d   = g5_d && dir_d;
    busy_d = (state_d != IDLE) || ep2_d;
  end

  // Control and output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      g5         <= 1'b0;
      shift_left <= 1'b0;
      ep2        <= 1'b0;
      busy       <= 1'b0;
      remaining  <= '0;
`ifdef SHIFT_SEQ_LONG_EN
      mc_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      g5         <= g5_d;
      shift_left <= sl_d;
      ep2        <= ep2_d;
      busy       <= busy_d;
      remaining  <= rem_d;
`ifdef SHIFT_SEQ_LONG_EN
      mc_q       <= mc_d;
`endif
    end
  end

  // Order latches carry data only; they are qualified by state, so no reset.
  always_ff @(posedge clk) begin
    n_q   <= n_d;
    dir_q <= dir_d;
`ifdef SHIFT_SEQ_LONG_EN
    long_q <= long_d;
`endif
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with an 18-clock d0 raster;
// the long-mode scenario is included when SHIFT_SEQ_LONG_EN is defined.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WPI = 18;
  localparam int OB  = 10;
  localparam int CW  = cnt_w(OB);

  logic          clk = 1'b0;
  logic          rst_n, d0, start, dir_left, abort;
  logic [OB-1:0] order_pos;
`ifdef SHIFT_SEQ_LONG_EN
  logic          long_mode;
`endif
  logic          g5, shift_left, ep2, busy;
  logic [CW-1:0] remaining;

  int cyc, errors, checks;
  int g5_cnt, g5_first, g5_last, ep2_cnt, ep2_first, busy_cnt, busy_last, sl_hi, sl_lo;
  int rem_at [0:255];

  shift_sequencer #(.WORD_PI(WPI), .ORDER_BITS(OB), .LONG_FACTOR(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (d0),
    .start      (start),
    .dir_left   (dir_left),
    .order_pos  (order_pos),
`ifdef SHIFT_SEQ_LONG_EN
    .long_mode  (long_mode),
`endif
    .abort      (abort),
    .g5         (g5),
    .shift_left (shift_left),
    .ep2        (ep2),
    .busy       (busy),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  // One clock: inputs set after this call are sampled by the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    d0    = (cyc % WPI == 0);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Advance until a d0 is k sampling edges ahead (k=0: d0 is being driven now).
  task automatic align(input int k);
    do tick(); while ((cyc % WPI) != ((WPI - k) % WPI));
  endtask

  // Record output activity over ncyc clocks; t=1 is the edge after the call.
  task automatic observe(input int ncyc);
    g5_cnt = 0; g5_first = -1; g5_last = -1; ep2_cnt = 0; ep2_first = -1;
    busy_cnt = 0; busy_last = -1; sl_hi = 0; sl_lo = 0;
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      rem_at[t] = int'(remaining);
      if (g5) begin
        g5_cnt++;
        if (g5_first < 0) g5_first = t;
        g5_last = t;
        if (shift_left) sl_hi++; else sl_lo++;
      end
      if (ep2) begin
        ep2_cnt++;
        if (ep2_first < 0) ep2_first = t;
      end
      if (busy) begin
        busy_cnt++;
        busy_last = t;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir_left = 1'b0; order_pos = '0;
    repeat (3) tick();
    checks++;
    if ({g5, shift_left, ep2, busy, remaining} !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b required=0", {g5, shift_left, ep2, busy, remaining});
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({g5, shift_left, ep2, busy, remaining} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet nonzero_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_shift_right();
    align(5);
    order_pos = 10'b0000001000; dir_left = 1'b0; start = 1'b1;
    observe(100);
    checks++; if (g5_first !== 6)  begin errors++; $display("FAIL r4_g5_first actual=%0d required=6", g5_first); end
    checks++; if (g5_cnt !== 72)   begin errors++; $display("FAIL r4_g5_len actual=%0d required=72", g5_cnt); end
    checks++; if (sl_hi !== 0)     begin errors++; $display("FAIL r4_shift_left actual=%0d required=0", sl_hi); end
    checks++; if (ep2_cnt !== 1)   begin errors++; $display("FAIL r4_ep2_cnt actual=%0d required=1", ep2_cnt); end
    checks++; if (ep2_first !== 78) begin errors++; $display("FAIL r4_ep2_at actual=%0d required=78", ep2_first); end
    checks++; if (busy_cnt !== 78 || busy_last !== 78) begin
      errors++; $display("FAIL r4_busy actual=%0d/%0d required=78/78", busy_cnt, busy_last);
    end
    checks++;
    if (rem_at[6] !== 4 || rem_at[23] !== 4 || rem_at[24] !== 3 || rem_at[42] !== 2 ||
        rem_at[60] !== 1 || rem_at[78] !== 0) begin
      errors++;
      $display("FAIL r4_remaining actual=%0d,%0d,%0d,%0d,%0d,%0d required=4,4,3,2,1,0",
               rem_at[6], rem_at[23], rem_at[24], rem_at[42], rem_at[60], rem_at[78]);
    end
  endtask

  task automatic test_zero_count();
    align(5);
    order_pos = '0; dir_left = 1'b0; start = 1'b1;
    observe(30);
    checks++; if (g5_cnt !== 0)    begin errors++; $display("FAIL zero_g5 actual=%0d required=0", g5_cnt); end
    checks++; if (ep2_cnt !== 1 || ep2_first !== 6) begin
      errors++; $display("FAIL zero_ep2 actual=%0d@%0d required=1@6", ep2_cnt, ep2_first);
    end
    checks++; if (busy_cnt !== 6 || busy_last !== 6) begin
      errors++; $display("FAIL zero_busy actual=%0d/%0d required=6/6", busy_cnt, busy_last);
    end
  endtask

  task automatic test_start_on_d0();
    align(0);
    order_pos = 10'b0000000001; dir_left = 1'b0; start = 1'b1;
    observe(60);
    checks++; if (g5_first !== 19) begin errors++; $display("FAIL d0co_g5_first actual=%0d required=19", g5_first); end
    checks++; if (g5_cnt !== 18)   begin errors++; $display("FAIL d0co_g5_len actual=%0d required=18", g5_cnt); end
    checks++; if (ep2_first !== 37) begin errors++; $display("FAIL d0co_ep2_at actual=%0d required=37", ep2_first); end
  endtask

  task automatic test_left_priority();
    align(3);
    order_pos = 10'b0000000110; dir_left = 1'b1; start = 1'b1;
    observe(60);
    checks++; if (g5_first !== 4 || g5_cnt !== 36) begin
      errors++; $display("FAIL left_g5 actual=%0d@%0d required=36@4", g5_cnt, g5_first);
    end
    checks++; if (sl_hi !== 36 || sl_lo !== 0) begin
      errors++; $display("FAIL left_shift_left actual=%0d/%0d required=36/0", sl_hi, sl_lo);
    end
    checks++; if (ep2_first !== 40) begin errors++; $display("FAIL left_ep2_at actual=%0d required=40", ep2_first); end
  endtask

  task automatic test_max_count();
    align(1);
    order_pos = 10'b1000000000; dir_left = 1'b0; start = 1'b1;
    observe(200);
    checks++; if (rem_at[2] !== 10) begin errors++; $display("FAIL max_remaining actual=%0d required=10", rem_at[2]); end
    checks++; if (g5_first !== 2 || g5_cnt !== 180) begin
      errors++; $display("FAIL max_g5 actual=%0d@%0d required=180@2", g5_cnt, g5_first);
    end
    checks++; if (ep2_first !== 182) begin errors++; $display("FAIL max_ep2_at actual=%0d required=182", ep2_first); end
  endtask

  task automatic test_back_to_back();
    int idle_t;
    idle_t = -1;
    align(5);
    order_pos = 10'b0000000001; dir_left = 1'b0; start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ep2) start = 1'b1;
      if (!busy && i > 1) begin
        idle_t = i;
        break;
      end
    end
    checks++; if (idle_t !== 25) begin errors++; $display("FAIL b2b_busy_fall actual=%0d required=25", idle_t); end
    order_pos = 10'b0000000010; dir_left = 1'b1; start = 1'b1;
    observe(60);
    checks++; if (g5_first !== 17 || g5_cnt !== 36) begin
      errors++; $display("FAIL b2b_second_g5 actual=%0d@%0d required=36@17", g5_cnt, g5_first);
    end
    checks++; if (ep2_first !== 53) begin errors++; $display("FAIL b2b_ep2_at actual=%0d required=53", ep2_first); end
  endtask

  task automatic test_abort();
    int found;
    found = 0;
    align(5);
    order_pos = 10'b0000001000; dir_left = 1'b0; start = 1'b1;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick();
      if (g5 && remaining == CW'(2)) found = 1;
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL abort_reach_rem2 actual=%0d required=1", found); end
    abort = 1'b1;
    tick();
    checks++;
    if ({g5, busy, ep2, remaining} !== '0) begin
      errors++; $display("FAIL abort_next_clock actual=%b required=0", {g5, busy, ep2, remaining});
    end
    observe(60);
    checks++; if (ep2_cnt !== 0 || g5_cnt !== 0 || busy_cnt !== 0) begin
      errors++; $display("FAIL abort_after actual=%0d/%0d/%0d required=0/0/0", ep2_cnt, g5_cnt, busy_cnt);
    end
    order_pos = 10'b0000000001; start = 1'b1; abort = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_start actual=%b required=0", busy); end
  endtask

`ifdef SHIFT_SEQ_LONG_EN
  task automatic test_long_mode();
    align(5);
    order_pos = 10'b0000000010; dir_left = 1'b0; long_mode = 1'b1; start = 1'b1;
    g5_cnt = 0; g5_first = -1; ep2_first = -1; busy_last = -1;
    for (int t = 1; t <= 180; t++) begin
      tick();
      if (t == 30) begin
        start = 1'b1; order_pos = 10'b0000000001; long_mode = 1'b0;
      end
      if (g5) begin
        g5_cnt++;
        if (g5_first < 0) g5_first = t;
      end
      if (ep2 && ep2_first < 0) ep2_first = t;
      if (busy) busy_last = t;
    end
    checks++; if (g5_first !== 6 || g5_cnt !== 144) begin
      errors++; $display("FAIL long_g5 actual=%0d@%0d required=144@6", g5_cnt, g5_first);
    end
    checks++; if (ep2_first !== 150) begin errors++; $display("FAIL long_ep2_at actual=%0d required=150", ep2_first); end
    checks++; if (busy_last !== 150) begin errors++; $display("FAIL long_busy_last actual=%0d required=150", busy_last); end
    long_mode = 1'b0;
  endtask
`endif

  initial begin
    cyc = 0; errors = 0; checks = 0;
    d0 = 1'b0; start = 1'b0; abort = 1'b0; dir_left = 1'b0; order_pos = '0; rst_n = 1'b0;
`ifdef SHIFT_SEQ_LONG_EN
    long_mode = 1'b0;
`endif
    test_reset();
    test_shift_right();
    test_zero_count();
    test_start_on_d0();
    test_left_priority();
    test_max_count();
    test_back_to_back();
    test_abort();
`ifdef SHIFT_SEQ_LONG_EN
    test_long_mode();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Parametrised shift-control unit for the arithmetic section.
- Decodes a shift order's position field into a shift count.
- Holds the accumulator shifting gate `g5` open for exactly that many word-time steps, aligned to the `d0` digit-timing pulse.
- Issues the termination pulse `ep2` at the end of the shift.
- Generalises the single-step shift control with a configurable order-field width and a configurable minor-cycle length. Adds an explicit start/busy handshake, abort, zero-count handling and an optional long-accumulator mode.

## Interface
Parameters:
- `WORD_PI`, 18, pulse intervals (clocks) per minor cycle; spacing of `d0` pulses.
- `ORDER_BITS`, 10, width of the order position field (O1..O10).
- `LONG_FACTOR`, 4, minor cycles per shift step in long mode (only with `SHIFT_SEQ_LONG_EN`).

Ports:
- `clk`  in  1  system clock, one pulse interval per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d0`  in  1  one-clock pulse marking digit 0 of each minor cycle, every `WORD_PI` clocks.
- `start`  in  1  one-clock shift order strobe.
- `dir_left`  in  1  1 = L order, 0 = R order; sampled with `start`.
- `order_pos`  in  `ORDER_BITS`  order position field; sampled with `start`.
- `long_mode`  in  1  double-length shift; sampled with `start` (only with `SHIFT_SEQ_LONG_EN`).
- `abort`  in  1  synchronous cancel.
- `g5`  out  1  accumulator shifting gate.
- `shift_left`  out  1  direction qualifier for `g5`; valid while `g5` is high.
- `ep2`  out  1  one-clock termination pulse.
- `busy`  out  1  order in progress.
- `remaining`  out  `$clog2(ORDER_BITS+1)`  shift steps still to perform.

## Operation
- Shift count: n = (index of the least significant set bit of `order_pos`) + 1.
  - Example: `order_pos` = 10'b0000001000 gives n = 4.
  - `order_pos` = 0 gives n = 0.
- State machine `IDLE -> ARM -> SHIFT -> IDLE`, with an `ARM -> IDLE` path for n = 0.
- `IDLE`
  - `start` with `busy`=0: latch n, `dir_left` and `long_mode`, then go to `ARM`.
  - `start` while `busy`=1 is ignored.
- `ARM`: wait for the first `d0` strictly after the `start` cycle. A `d0` coincident with `start` does not count.
  - n = 0: pulse `ep2`, return to `IDLE`; `g5` never rises.
  - n > 0: go to `SHIFT` and load the step counter with n.
- `SHIFT`
  - `g5` is high.
  - Every step boundary `d0` decrements `remaining`.
  - In long mode a step boundary is every `LONG_FACTOR`-th `d0`, tracked by an internal minor-cycle counter.
  - The `d0` that takes `remaining` to 0 ends the shift: `g5` falls, `ep2` pulses, go to `IDLE`.
- `abort` in any state: go to `IDLE` next clock, `g5`=0, `remaining`=0, no `ep2`. `abort` has priority over `start` and `d0`.
- Reset values: state `IDLE`; `g5`, `shift_left`, `ep2`, `busy` all 0; `remaining` = 0.

## Timing
- All outputs are registered; each responds one clock after its cause.
- `busy` rises the clock after an accepted `start`. It falls the clock after `ep2` is high; `ep2` and `busy` overlap for one clock.
- `g5` rises the clock after the arming `d0`. It stays high for exactly n×`WORD_PI` clocks, or n×`LONG_FACTOR`×`WORD_PI` in long mode.
- `ep2` is high for exactly the clock after the terminating `d0`, coincident with the first clock of `g5` low.
- Zero count: `ep2` the clock after the arming `d0`.
- Latency from `start` to `ep2`: wait to the next `d0` (up to `WORD_PI` clocks), then one clock, plus the shift duration.
- Back-to-back orders: a `start` on the first clock with `busy`=0 is accepted. It arms on the next `d0`, so there is no lost minor cycle beyond alignment.

## Configuration
- `SHIFT_SEQ_LONG_EN` defined:
  - The `long_mode` port and the `LONG_FACTOR` step counter exist.
  - With `long_mode`=1, each step spans `LONG_FACTOR` minor cycles.
- `SHIFT_SEQ_LONG_EN` undefined:
  - No `long_mode` port.
  - Every step is one minor cycle; `LONG_FACTOR` is unused.

## Structure
- Package `shift_seq_pkg` holds:
  - the state enum (`IDLE`, `ARM`, `SHIFT`);
  - the count-width constant function;
  - the default `WORD_PI` and `ORDER_BITS` constants.
- Sub-module `lsb_encoder`: combinational priority encoder from `order_pos` to n. It is parametrised by `ORDER_BITS` and outputs 0 for an all-zero input.

## Test plan
- Reset, no `start` → all outputs 0 for 100 clocks, including across `d0` pulses.
- `order_pos`=10'b0000001000, `dir_left`=0, `start` 5 clocks before `d0` → `g5` high for 72 clocks starting 1 clock after that `d0`; `shift_left`=0; `remaining` steps 4→3→2→1→0; `ep2` high for 1 clock as `g5` falls.
- `order_pos`=0 → no `g5`; `ep2` one clock after the next `d0`; `busy` high for the intervening clocks only.
- `start` coincident with `d0`, `order_pos`=10'b0000000001 → arming waits for the following `d0`; `g5` high for 18 clocks.
- `abort` mid-`SHIFT` with `remaining`=2 → next clock `g5`=0, `busy`=0, `remaining`=0, no `ep2`.
- `SHIFT_SEQ_LONG_EN`, `long_mode`=1, n=2 → `g5` high for 144 clocks; a second `start` during `busy` is ignored.
